lfsr_bank: RTL

// - Multi-lane pseudo-random source for stochastic rounding / dither in the arithmetic units.
// - LANES independent XNOR Fibonacci LFSRs with leap-forward stepping (STEP shifts per draw).
// - Valid/ready output stream, per-lane runtime seeding and all-ones lockup detection/repair.
// - Successor to the single-lane fixed-step generator: adds lanes, stepping, handshake, seeding.

---
 rtl/lfsr_pkg.sv | 32 +++
 rtl/lfsr_bank_if.sv | 31 +++
 rtl/lfsr_leap.sv | 54 +++++
 rtl/lfsr_bank.sv | 91 +++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the leap-forward LFSR bank: supported lengths, tap table,
// lane-select width helper and the sequencer state type.
package lfsr_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } fsm_t;

    function automatic bit lfsr_legal(input int len);
        return (len == 9) || (len == 17) || (len == 25) ||
               (len == 33) || (len == 41) || (len == 63);
    endfunction

    // Second feedback tap; the first is always the MSB.
    function automatic int lfsr_tap(input int len);
        case (len)
            9:       return 4;
            17:      return 13;
            25:      return 21;
            33:      return 19;
            41:      return 37;
            63:      return 61;
            default: return 0;
        endcase
    endfunction

    function automatic int lane_bits(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/lfsr_bank_if.sv
// Seed-write and draw-stream signals of the LFSR bank. master = host/consumer side,
// slave = the bank itself.
interface lfsr_bank_if
    import lfsr_pkg::*;
#(
    parameter int LANES = 4,
    parameter int STATE = 17,
    parameter int WIDTH = 16
);
    localparam int LW = lane_bits(LANES);

    logic                   seed_valid;
    logic [LW-1:0]          seed_lane;
    logic [STATE-1:0]       seed_data;
    logic                   seed_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   lockup;

    modport master (
        output seed_valid, seed_lane, seed_data, out_ready,
        input  seed_ready, out_valid, out_data, lockup
    );

    modport slave (
        input  seed_valid, seed_lane, seed_data, out_ready,
        output seed_ready, out_valid, out_data, lockup
    );

endinterface

// File: rtl/lfsr_leap.sv
// One XNOR Fibonacci lane: state register, STEP-shift leap unrolled in one cycle,
// seed load and all-ones lockup repair.
module lfsr_leap
    import lfsr_pkg::*;
#(
    parameter int STATE = 17,
    parameter int WIDTH = 16,
    parameter int STEP  = 16,
    parameter int INIT  = 0
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             run,
    input  logic             load,
    input  logic             advance,
    input  logic [STATE-1:0] seed,
    output logic [WIDTH-1:0] draw,
    output logic             repair
);
    localparam int               TAP   = lfsr_tap(STATE);
    localparam logic [STATE-1:0] ONES  = '1;
    localparam logic [STATE-1:0] FIXED = {{(STATE-1){1'b1}}, 1'b0};

    logic [STATE-1:0] state;
    logic [STATE-1:0] leap;
    logic             seed_locked;
    logic             state_locked;

    always_comb begin
        leap = state;
        for (int k = 0; k < STEP; k++) begin
            leap = {leap[STATE-2:0], leap[STATE-1] ~^ leap[TAP]};
        end
    end

    // All-ones is the XNOR fixed point; it is replaced rather than ever stored.
    assign seed_locked  = (seed == ONES);
    assign state_locked = run && (state == ONES);
    assign repair       = load ? seed_locked : state_locked;
    assign draw         = state[WIDTH-1:0];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= STATE'(INIT);
        end else if (load) begin
            state <= seed_locked ? FIXED : seed;
        end else if (state_locked) begin
            state <= FIXED;
        end else if (advance) begin
            state <= leap;
        end
    end

endmodule

// File: rtl/lfsr_bank.sv
// Multi-lane leap-forward LFSR source with valid/ready draw stream, per-lane
// runtime seeding and sticky lockup indication.
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int LANES = 4,
    parameter int STATE = 17,
    parameter int WIDTH = 16,
    parameter int STEP  = 16
) (
    input  logic        clock,
    input  logic        resetN,
    lfsr_bank_if.slave  bus
);
    localparam int LW = lane_bits(LANES);

    if (!lfsr_legal(STATE)) begin : g_bad_state
        $error("lfsr_bank: unsupported STATE %0d", STATE);
    end
    if ((WIDTH < 1) || (WIDTH > STATE)) begin : g_bad_width
        $error("lfsr_bank: WIDTH %0d out of range", WIDTH);
    end
    if ((STEP < 1) || (STEP > STATE)) begin : g_bad_step
        $error("lfsr_bank: STEP %0d out of range", STEP);
    end

    fsm_t             fsm;
    logic             seed_take;
    logic             draw_take;
    logic             capture;
    logic [LANES-1:0] repair;
    logic [WIDTH-1:0] draw [LANES];

    assign seed_take = (fsm == RUN) && bus.seed_valid;
    assign draw_take = (fsm == RUN) && bus.out_valid && bus.out_ready;
    // A seed freezes every lane so the draw after PRIME continues without a skip.
    assign capture   = (fsm == PRIME) || (draw_take && !seed_take);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lfsr_leap #(
            .STATE (STATE),
            .WIDTH (WIDTH),
            .STEP  (STEP),
            .INIT  (i)
        ) u_leap (
            .clock   (clock),
            .resetN  (resetN),
            .run     (fsm == RUN),
            .load    (seed_take && (bus.seed_lane == LW'(i))),
            .advance (capture),
            .seed    (bus.seed_data),
            .draw    (draw[i]),
            .repair  (repair[i])
        );
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fsm            <= PRIME;
            bus.out_valid  <= 1'b0;
            bus.seed_ready <= 1'b0;
            bus.out_data   <= '0;
            bus.lockup     <= 1'b0;
        end else begin
            if (|repair) begin
                bus.lockup <= 1'b1;
            end
            case (fsm)
                PRIME: begin
                    bus.out_valid  <= 1'b1;
                    bus.seed_ready <= 1'b1;
                    fsm            <= RUN;
                end
                RUN: begin
                    if (seed_take) begin
                        bus.out_valid  <= 1'b0;
                        bus.seed_ready <= 1'b0;
                        fsm            <= PRIME;
                    end
                end
                default: fsm <= PRIME;
            endcase
            if (capture) begin
                for (int l = 0; l < LANES; l++) begin
                    bus.out_data[l*WIDTH +: WIDTH] <= draw[l];
                end
            end
        end
    end

endmodule
